// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: stage k applies a 2^k shift/rotate step when shift bit k is set.
// The whole pipe advances or stalls together under a valid/ready handshake.
module barrel_shifter_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [SHW-1:0]   i_shift,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_data_out,
    output logic [15:0]      o_done_count
);

    logic        w_adv;
    logic [15:0] r_doneCount;

    // One fixed-size step; mode 11 and arithmetic-left fall through to the logical shift.
    function automatic logic [WIDTH-1:0] stepShift(
        input logic [WIDTH-1:0] d,
        input int               amt,
        input logic             dir,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] fillMask;
        fillMask = ~({WIDTH{1'b1}} >> amt);
        if (mode == 2'b10) begin
            if (dir)
                result = (d >> amt) | (d << (WIDTH - amt));
            else
                result = (d << amt) | (d >> (WIDTH - amt));
        end else if (mode == 2'b01 && dir) begin
            result = (d >> amt) | (sign ? fillMask : '0);
        end else if (dir) begin
            result = d >> amt;
        end else begin
            result = d << amt;
        end
        return result;
    endfunction

    assign w_adv      = !o_out_valid || i_out_ready;
    assign o_in_ready = w_adv;

    for (genvar k = 0; k < SHW; k++) begin : gStage
        logic             w_srcValid;
        logic [WIDTH-1:0] w_srcData;
        logic             w_srcBit;
        logic             w_srcDir;
        logic [1:0]       w_srcMode;
        logic             w_srcSign;
        logic             r_valid;
        logic [WIDTH-1:0] r_data;

        if (k == 0) begin : gSrc
            assign w_srcValid = i_in_valid;
            assign w_srcData  = i_data_in;
            assign w_srcBit   = i_shift[0];
            assign w_srcDir   = i_dir;
            assign w_srcMode  = i_mode;
            assign w_srcSign  = i_data_in[WIDTH-1];
        end else begin : gSrc
            assign w_srcValid = gStage[k-1].r_valid;
            assign w_srcData  = gStage[k-1].r_data;
            assign w_srcBit   = gStage[k-1].gCtrl.r_shift[k];
            assign w_srcDir   = gStage[k-1].gCtrl.r_dir;
            assign w_srcMode  = gStage[k-1].gCtrl.r_mode;
            assign w_srcSign  = gStage[k-1].gCtrl.r_sign;
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_adv) begin
                r_valid <= w_srcValid;
                r_data  <= w_srcBit ? stepShift(w_srcData, 1 << k, w_srcDir, w_srcMode, w_srcSign)
                                    : w_srcData;
            end
        end

        // The last stage needs no control fields, since nothing follows it.
        if (k < SHW - 1) begin : gCtrl
            logic [SHW-1:0] w_srcShift;
            logic           r_dir;
            logic [1:0]     r_mode;
            logic [SHW-1:0] r_shift;
            logic           r_sign;

            if (k == 0) begin : gShiftSrc
                assign w_srcShift = i_shift;
            end else begin : gShiftSrc
                assign w_srcShift = gStage[k-1].gCtrl.r_shift;
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_dir   <= 1'b0;
                    r_mode  <= 2'b00;
                    r_shift <= '0;
                    r_sign  <= 1'b0;
                end else if (w_adv) begin
                    r_dir   <= w_srcDir;
                    r_mode  <= w_srcMode;
                    r_shift <= w_srcShift;
                    r_sign  <= w_srcSign;
                end
            end
        end
    end

    assign o_out_valid = gStage[SHW-1].r_valid;
    assign o_data_out  = gStage[SHW-1].r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_doneCount <= '0;
        else if (o_out_valid && i_out_ready && r_doneCount != 16'hFFFF)
            r_doneCount <= r_doneCount + 16'd1;
    end

    assign o_done_count = r_doneCount;

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; SHALL be a power of two and at least 4.
REQ-002 Derived constant: SHW = log2(WIDTH), shift-amount width and pipeline depth (3 at default).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream presents an operation.
REQ-007 in_ready  output  1  block can accept an operation this cycle.
REQ-008 data_in  input  WIDTH  operand.
REQ-009 shift  input  SHW  shift or rotate amount, 0 to WIDTH-1.
REQ-010 dir  input  1  direction: 0 = left, 1 = right.
REQ-011 mode  input  2  operation: 00 logical, 01 arithmetic, 10 rotate, 11 reserved.
REQ-012 out_valid  output  1  data_out holds a completed result.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 data_out  output  WIDTH  shifted result.
REQ-015 done_count  output  16  count of results delivered.

Function
REQ-016 Operation per mode SHALL be as follows.
- Logical: vacated bits filled with 0.
- Arithmetic right: vacated bits filled with data_in[WIDTH-1].
- Arithmetic left: identical to logical left.
- Rotate: bits shifted out re-enter at the opposite end.
- Mode 11: SHALL behave exactly as mode 00.
REQ-017 The datapath SHALL be SHW registered stages.
- Stage k applies a shift or rotate of 2^k when shift[k]=1 and passes data unchanged otherwise.
- Stage k carries its valid bit, dir, mode, remaining shift bits and original sign bit.
REQ-018 shift=0 SHALL return data_in unchanged for every mode and dir.
REQ-019 Advance enable: adv = !out_valid || out_ready.
- All stages SHALL load on clk only when adv=1.
- All stages SHALL hold their contents when adv=0.
REQ-020 Handshake rules.
- in_ready SHALL equal adv.
- An operation is accepted on an edge where in_valid && in_ready.
- When in_valid=0 on an advancing edge, a bubble (valid=0) SHALL enter stage 0.
REQ-021 Latency: an operation accepted at edge E SHALL appear with out_valid=1 immediately after edge E+SHW-1 when no stall occurs.
- Throughput: one operation per cycle.
REQ-022 Stall behaviour.
- While out_valid=1 && out_ready=0, data_out and out_valid SHALL be stable.
- No operation SHALL be lost or duplicated during a stall.
REQ-023 Ordering: results SHALL leave in acceptance order.
- Bubbles are not collapsed.
- out_valid=0 cycles SHALL not stall upstream.
REQ-024 done_count SHALL increment by 1 on each edge where out_valid && out_ready.
- It SHALL saturate at 16'hFFFF and never wrap.
REQ-025 in_ready, out_valid and data_out SHALL depend only on registered state and out_ready.
- There SHALL be no combinational path from in_valid or data_in to any output.

Reset
REQ-026 On rst_n=0, the following SHALL clear immediately, without waiting for clk:
- all stage valid bits;
- out_valid = 0, data_out = 0, done_count = 0;
- all stage data and control registers.
REQ-027 Reset mid-operation SHALL discard every in-flight operation; none SHALL appear after release.
REQ-028 While rst_n=0, in_ready SHALL be 1 (out_valid=0); no operation SHALL be accepted until the first edge after rst_n rises.

Verification (WIDTH=8, data_in=8'hB2 unless noted)
REQ-029 Mode 00, dir 0, shift 3, out_ready=1 -> data_out=8'h90 with out_valid=1 after accept edge +2; then mode 00, dir 1, shift 4 -> 8'h0B.
REQ-030 Mode 01, dir 1, shift 2 -> 8'hEC; data_in=8'h72, same controls -> 8'h1C; mode 01, dir 0, shift 1 -> 8'h64.
REQ-031 Mode 10, dir 1, shift 3 -> 8'h56; mode 10, dir 0, shift 1 -> 8'h65; any mode with shift 0 -> 8'hB2.
REQ-032 Back-to-back stream of 8 operations with out_ready=0 for 5 cycles mid-stream:
- in_ready drops while out_valid=1;
- data_out is held during the stall;
- all 8 results arrive in order;
- done_count=8.
REQ-033 Assert rst_n=0 between clock edges with 2 operations in flight -> out_valid and done_count drop to 0 at once; no result emerges after release.
REQ-034 Preload done_count to 16'hFFFE via a forced run, deliver 3 results -> done_count reads 16'hFFFF.
